// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - reset / stall-request active levels
//   - stage index constants (pc = youngest ... wb = oldest)
//   - FSM state encoding for the deferred-flush tracker
package pipe_hazard_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;  // rst level that resets the block
  localparam logic STOP       = 1'b1;  // stall_req level that requests a hold

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline stages and pipe_hazard_ctrl.
//   stall_req/flush_req : per-stage requests from the pipeline (master drives)
//   stall_ctrl/bubble_ctrl/flush_ctrl : per-stage enables/clears (slave drives)
//   flush_pending, stall_timeout : status
//   perf_stall_cnt (NUM_STAGES*PERF_W, slice i = stage i), perf_flush_cnt : counters
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 6,
  parameter int PERF_W     = 32
);
  logic [NUM_STAGES-1:0]        stall_req;
  logic [NUM_STAGES-1:0]        flush_req;
  logic [NUM_STAGES-1:0]        stall_ctrl;
  logic [NUM_STAGES-1:0]        bubble_ctrl;
  logic [NUM_STAGES-1:0]        flush_ctrl;
  logic                         flush_pending;
  logic                         stall_timeout;
  logic [NUM_STAGES*PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0]            perf_flush_cnt;

  modport master (
    output stall_req, flush_req,
    input  stall_ctrl, bubble_ctrl, flush_ctrl, flush_pending, stall_timeout,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  stall_req, flush_req,
    output stall_ctrl, bubble_ctrl, flush_ctrl, flush_pending, stall_timeout,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_prio_enc.sv
// pipe_prio_enc: highest-set-bit encoder.
//   i_vec : input vector
//   o_vld : any bit set
//   o_idx : index of the highest set bit (0 when none set)
module pipe_prio_enc #(
  parameter int W     = 6,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     i_vec,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);
  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++)
      if (i_vec[i]) o_idx = IDX_W'(i);
  end

  assign o_vld = |i_vec;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble controller for an in-order pipeline.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : stall_req/flush_req in; stall_ctrl/bubble_ctrl/flush_ctrl,
//                  flush_pending, stall_timeout, perf counters out
// Stage 0 is the youngest (pc), NUM_STAGES-1 the oldest (wb).
// Optional feature macro: PIPE_CTRL_PERF_EN enables the performance counters;
// without it the counter outputs are tied to 0.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 1023,
  parameter int PERF_W     = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STAGES);

  hz_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_pend_idx, w_pend_idx_nxt;

  logic [NUM_STAGES-1:0] w_flush_vec;
  logic [NUM_STAGES-1:0] w_stall_src;
  logic [NUM_STAGES-1:0] w_fmask;
  logic [NUM_STAGES-1:0] w_stall_ctrl;
  logic [NUM_STAGES-1:0] w_bubble;
  logic                  w_fl_vld, w_st_vld;
  logic [IDX_W-1:0]      w_fl_idx, w_st_idx;
  logic                  w_blocked, w_flush_apply, w_any_stall;

  logic [WDOG_W-1:0]     r_cnt, w_cnt_nxt;
  logic                  r_timeout;

  // Flush candidates: live redirects (stage 0 cannot redirect) plus the
  // deferred index, so the oldest of the two wins.
  always_comb begin
    w_flush_vec = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      w_flush_vec[i] = ((i != 0) && bus.flush_req[i]) ||
                       ((r_state == ST_PEND) && (r_pend_idx == IDX_W'(i)));
  end

  pipe_prio_enc #(.W(NUM_STAGES), .IDX_W(IDX_W)) u_flush_enc (
    .i_vec (w_flush_vec),
    .o_vld (w_fl_vld),
    .o_idx (w_fl_idx)
  );

  // Stages younger than the flush source are being squashed, so their stall
  // requests are dropped. If any stage at or above the source still stalls,
  // the flush cannot land yet.
  always_comb begin
    w_stall_src = '0;
    w_fmask     = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_stall_src[i] = (bus.stall_req[i] == STOP) &&
                       (!w_fl_vld || (IDX_W'(i) >= w_fl_idx));
      w_fmask[i]     = w_fl_vld && (IDX_W'(i) < w_fl_idx);
    end
  end

  assign w_blocked     = w_fl_vld && (|w_stall_src);
  assign w_flush_apply = w_fl_vld && !w_blocked;

  pipe_prio_enc #(.W(NUM_STAGES), .IDX_W(IDX_W)) u_stall_enc (
    .i_vec (w_stall_src),
    .o_vld (w_st_vld),
    .o_idx (w_st_idx)
  );

  // Hold everything at and below the originator; NOP goes into the stage
  // just above it (none when the originator is the oldest stage).
  always_comb begin
    w_stall_ctrl = '0;
    w_bubble     = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_stall_ctrl[i] = w_st_vld && (IDX_W'(i) <= w_st_idx);
      if (i > 0)
        w_bubble[i] = w_st_vld && (w_st_idx == IDX_W'(i - 1));
    end
  end

  assign w_any_stall = |w_stall_ctrl;

  // Deferred-flush FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state    <= ST_IDLE;
      r_pend_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_idx <= w_pend_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_idx_nxt = r_pend_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_fl_vld && w_blocked) begin
          w_state_nxt    = ST_PEND;
          w_pend_idx_nxt = w_fl_idx;
        end
      end
      ST_PEND: begin
        if (w_flush_apply) begin
          w_state_nxt    = ST_IDLE;
          w_pend_idx_nxt = '0;
        end else begin
          // w_fl_idx already includes r_pend_idx, so this is the merged max
          w_pend_idx_nxt = w_fl_idx;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_pend_idx_nxt = '0;
      end
    endcase
  end

  // Stall watchdog: saturating run-length of consecutive stall cycles.
  always_comb begin
    if (!w_any_stall)
      w_cnt_nxt = '0;
    else if (r_cnt == {WDOG_W{1'b1}})
      w_cnt_nxt = r_cnt;
    else
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_any_stall && (w_cnt_nxt >= WDOG_W'(WDOG_LIMIT));
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign bus.stall_ctrl    = rst ? '0 : w_stall_ctrl;
  assign bus.bubble_ctrl   = rst ? '0 : w_bubble;
  assign bus.flush_ctrl    = (rst || !w_flush_apply) ? '0 : w_fmask;
  assign bus.flush_pending = !rst && (r_state == ST_PEND);
  assign bus.stall_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [NUM_STAGES-1:0][PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0]                 r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++)
        if (w_st_vld && (w_st_idx == IDX_W'(i)))
          r_perf_stall[i] <= r_perf_stall[i] + 1'b1;
      if (w_flush_apply)
        r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall;
  assign bus.perf_flush_cnt = r_perf_flush;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int N   = 6;
  localparam int LIM = 1023;
  localparam int PW  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(N), .PERF_W(PW)) u_if ();

  pipe_hazard_ctrl #(
    .NUM_STAGES(N), .WDOG_W(16), .WDOG_LIMIT(LIM), .PERF_W(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int exp_fl = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [N-1:0] s, input logic [N-1:0] f);
    u_if.stall_req = s;
    u_if.flush_req = f;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    u_if.stall_req = '0;
    u_if.flush_req = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, combinational outputs gated even with a request present
    drv(6'b010000, 6'b001000);
    chk("rst_stall",   u_if.stall_ctrl, 6'b0);
    chk("rst_bubble",  u_if.bubble_ctrl, 6'b0);
    chk("rst_flush",   u_if.flush_ctrl, 6'b0);
    chk("rst_pend",    u_if.flush_pending, 1'b0);
    chk("rst_tmo",     u_if.stall_timeout, 1'b0);
    chk("rst_pflush",  u_if.perf_flush_cnt, 32'd0);
    drv(6'b0, 6'b0);
    rst = 1'b0;

    // stall prefix and bubble
    drv(6'b010000, 6'b0);
    chk("st4_stall",  u_if.stall_ctrl, 6'b011111);
    chk("st4_bubble", u_if.bubble_ctrl, 6'b100000);
    chk("st4_flush",  u_if.flush_ctrl, 6'b0);
    nxt();
    drv(6'b100000, 6'b0);
    chk("st5_stall",  u_if.stall_ctrl, 6'b111111);
    chk("st5_bubble", u_if.bubble_ctrl, 6'b000000);
    nxt();
    drv(6'b000101, 6'b0);
    chk("st2_stall",  u_if.stall_ctrl, 6'b000111);
    chk("st2_bubble", u_if.bubble_ctrl, 6'b001000);
    nxt();

    // unblocked flush, same cycle
    drv(6'b0, 6'b001000);
    chk("fl3_flush", u_if.flush_ctrl, 6'b000111);
    chk("fl3_pend",  u_if.flush_pending, 1'b0);
    exp_fl++;
    nxt();
    drv(6'b0, 6'b0);
    chk("fl3_after", u_if.flush_ctrl, 6'b0);
    chk("fl3_pend2", u_if.flush_pending, 1'b0);
    nxt();

    // blocked flush deferred for 3 cycles
    drv(6'b100000, 6'b001000);
    chk("blk_flush", u_if.flush_ctrl, 6'b0);
    chk("blk_stall", u_if.stall_ctrl, 6'b111111);
    chk("blk_pend0", u_if.flush_pending, 1'b0);
    nxt();
    drv(6'b100000, 6'b0);
    chk("blk_pend1", u_if.flush_pending, 1'b1);
    chk("blk_fl1",   u_if.flush_ctrl, 6'b0);
    nxt();
    chk("blk_pend2", u_if.flush_pending, 1'b1);
    nxt();
    chk("blk_pend3", u_if.flush_pending, 1'b1);
    drv(6'b0, 6'b0);
    chk("blk_apply", u_if.flush_ctrl, 6'b000111);
    exp_fl++;
    nxt();
    chk("blk_idle",  u_if.flush_pending, 1'b0);
    chk("blk_done",  u_if.flush_ctrl, 6'b0);

    // merge in PEND: idx 3 then pulse 4, applied on release
    drv(6'b100000, 6'b001000);
    nxt();
    drv(6'b100000, 6'b010000);
    chk("mrg_pend",  u_if.flush_pending, 1'b1);
    chk("mrg_blk",   u_if.flush_ctrl, 6'b0);
    nxt();
    drv(6'b0, 6'b0);
    chk("mrg_apply", u_if.flush_ctrl, 6'b001111);
    exp_fl++;
    nxt();
    chk("mrg_idle",  u_if.flush_pending, 1'b0);

    // unblocked younger flush in PEND applies the older pending index
    drv(6'b100000, 6'b010000);
    nxt();
    drv(6'b0, 6'b001000);
    chk("mrg2_apply", u_if.flush_ctrl, 6'b001111);
    exp_fl++;
    nxt();
    drv(6'b0, 6'b0);
    chk("mrg2_idle", u_if.flush_pending, 1'b0);

    // younger stall ignored against a flush
    drv(6'b000010, 6'b001000);
    chk("ign_stall",  u_if.stall_ctrl, 6'b0);
    chk("ign_bubble", u_if.bubble_ctrl, 6'b0);
    chk("ign_flush",  u_if.flush_ctrl, 6'b000111);
    exp_fl++;
    nxt();

    // flush_req bit 0 has no effect
    drv(6'b0, 6'b000001);
    chk("b0_flush", u_if.flush_ctrl, 6'b0);
    nxt();
    chk("b0_pend",  u_if.flush_pending, 1'b0);

    // stall at the flush source itself blocks it
    drv(6'b001000, 6'b001000);
    chk("eq_flush",  u_if.flush_ctrl, 6'b0);
    chk("eq_stall",  u_if.stall_ctrl, 6'b001111);
    chk("eq_bubble", u_if.bubble_ctrl, 6'b010000);
    nxt();
    drv(6'b0, 6'b0);
    chk("eq_pend",   u_if.flush_pending, 1'b1);
    chk("eq_apply",  u_if.flush_ctrl, 6'b000111);
    exp_fl++;
    nxt();

`ifdef PIPE_CTRL_PERF_EN
    chk("perf_flush", u_if.perf_flush_cnt, 64'(exp_fl));
`else
    chk("perf_flush_off", u_if.perf_flush_cnt, 32'd0);
`endif

    // watchdog
    drv(6'b000001, 6'b0);
    chk("wd_stall",  u_if.stall_ctrl, 6'b000001);
    chk("wd_bubble", u_if.bubble_ctrl, 6'b000010);
    repeat (LIM - 1) @(posedge clk);
    #1;
    chk("wd_below", u_if.stall_timeout, 1'b0);
    nxt();
    chk("wd_limit", u_if.stall_timeout, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("wd_hold",  u_if.stall_timeout, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_st0", u_if.perf_stall_cnt[0 +: PW], 64'(LIM + 2));
`else
    chk("perf_st0_off", u_if.perf_stall_cnt[0 +: PW], 32'd0);
`endif
    drv(6'b0, 6'b0);
    nxt();
    chk("wd_clear", u_if.stall_timeout, 1'b0);

    // reset mid-PEND discards the pending flush
    drv(6'b100000, 6'b010000);
    nxt();
    drv(6'b100000, 6'b0);
    chk("rp_pend", u_if.flush_pending, 1'b1);
    rst = 1'b1;
    #1;
    chk("rp_stall",  u_if.stall_ctrl, 6'b0);
    chk("rp_pend0",  u_if.flush_pending, 1'b0);
    chk("rp_flush",  u_if.flush_ctrl, 6'b0);
    chk("rp_pflush", u_if.perf_flush_cnt, 32'd0);
    chk("rp_pst0",   u_if.perf_stall_cnt[0 +: PW], 32'd0);
    nxt();
    rst = 1'b0;
    drv(6'b0, 6'b0);
    chk("rp_noflush", u_if.flush_ctrl, 6'b0);
    chk("rp_idle",    u_if.flush_pending, 1'b0);
    nxt();
    chk("rp_idle2",   u_if.flush_pending, 1'b0);
    chk("rp_noflush2", u_if.flush_ctrl, 6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
